uart_fifo_ctrl: RTL and testbench

Command executor downstream of the UART front-end parser. Takes the parsed `cmd` byte and 16-bit `rx_cnt`, then stores incoming payload bytes into an internal byte FIFO, streams stored bytes to the UART transmitter, or clears the FIFO. It drives the `fifo_busy` / `fifo_done` handshake that holds `cmd` stable in the parser and re-arms its header counter after every transaction.

---
 rtl/uart_fifo_pkg.sv | 17 +
 rtl/uart_fifo_ram.sv | 34 +++
 rtl/uart_fifo_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_uart_fifo_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_fifo_pkg.sv
// rtl/uart_fifo_pkg.sv - shared state encoding and default command codes for uart_fifo_ctrl
package uart_fifo_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR     = 3'd1,
        RD_REQ = 3'd2,
        RD_OUT = 3'd3,
        DONE   = 3'd4
    } state_e;

    localparam logic [7:0]  CMD_WR      = 8'h01;
    localparam logic [7:0]  CMD_RD      = 8'h02;
    localparam logic [7:0]  CMD_CLR     = 8'h03;
    localparam int unsigned TIMEOUT_CYC = 1_000_000;

endpackage

// File: rtl/uart_fifo_ram.sv
// rtl/uart_fifo_ram.sv - DEPTHx8 simple dual-port RAM, synchronous write, registered 1-cycle read
module uart_fifo_ram #(
    parameter  int unsigned DEPTH = 256,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rdata_q;

    // Write port: store the byte at the write address.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read port: data only updates on a read request, so it stays stable while the consumer stalls.
    always_ff @(posedge clk) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/uart_fifo_ctrl.sv
// rtl/uart_fifo_ctrl.sv - UART command executor with byte FIFO; optional WR timeout under UART_FIFO_TIMEOUT_EN
module uart_fifo_ctrl #(
    parameter  int unsigned DEPTH       = 256,
    parameter  logic [7:0]  CMD_WR      = uart_fifo_pkg::CMD_WR,
    parameter  logic [7:0]  CMD_RD      = uart_fifo_pkg::CMD_RD,
    parameter  logic [7:0]  CMD_CLR     = uart_fifo_pkg::CMD_CLR,
`ifdef UART_FIFO_TIMEOUT_EN
    parameter  int unsigned TIMEOUT_CYC = uart_fifo_pkg::TIMEOUT_CYC,
`endif
    localparam int unsigned AW          = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    cmd,
    input  logic [15:0]   rx_cnt,
    input  logic          rok,
    input  logic [7:0]    mosi,
    input  logic          tx_ready,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    output logic          fifo_busy,
    output logic          fifo_done,
    output logic [AW:0]   level,
    output logic          err
);

    import uart_fifo_pkg::*;

    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    state_e      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [15:0] bcnt_q, bcnt_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        err_q, err_d;
    logic        ram_we, ram_re;
    logic [7:0]  ram_rdata;
    logic        full, empty;

`ifdef UART_FIFO_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] idle_q, idle_d;
`endif

    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    uart_fifo_ram #(.DEPTH(DEPTH)) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (mosi),
        .re_i    (ram_re),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (ram_rdata)
    );

    // Next-state and datapath control for the command FSM.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        bcnt_d   = bcnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        err_d    = err_q;
        ram_we   = 1'b0;
        ram_re   = 1'b0;
`ifdef UART_FIFO_TIMEOUT_EN
        idle_d   = (state_q != WR || rok) ? {{(TW-1){1'b0}}, 1'b1} : idle_q + 1'b1;
`endif
        case (state_q)
            IDLE: begin
                if (cmd != 8'h00) begin
                    len_d  = rx_cnt;
                    bcnt_d = 16'd0;
                    if (cmd == CMD_WR) begin
                        state_d = WR;
                    end else if (cmd == CMD_RD) begin
                        state_d = RD_REQ;
                    end else begin
                        // CLR and unknown codes pass through RD_REQ with a zero count, giving
                        // the parser the same two busy cycles before the done pulse.
                        len_d   = 16'd0;
                        state_d = RD_REQ;
                        if (cmd == CMD_CLR) begin
                            wr_ptr_d = '0;
                            rd_ptr_d = '0;
                            err_d    = 1'b0;
                        end else begin
                            err_d    = 1'b1;
                        end
                    end
                end
            end
            WR: begin
                if (bcnt_q == len_q) begin
                    state_d = DONE;
                end else if (rok) begin
                    if (full) begin
                        err_d = 1'b1;
                    end else begin
                        ram_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_ONE;
                    end
                    bcnt_d = bcnt_q + 16'd1;
                    if (bcnt_q + 16'd1 == len_q) begin
                        state_d = DONE;
                    end
                end
`ifdef UART_FIFO_TIMEOUT_EN
                else if (idle_q == TW'(TIMEOUT_CYC - 1)) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
`endif
            end
            RD_REQ: begin
                if (bcnt_q == len_q) begin
                    state_d = DONE;
                end else if (empty) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    ram_re  = 1'b1;
                    state_d = RD_OUT;
                end
            end
            RD_OUT: begin
                if (tx_ready) begin
                    rd_ptr_d = rd_ptr_q + PTR_ONE;
                    bcnt_d   = bcnt_q + 16'd1;
                    state_d  = RD_REQ;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, pointer and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            len_q    <= 16'd0;
            bcnt_q   <= 16'd0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            bcnt_q   <= bcnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            err_q    <= err_d;
        end
    end

`ifdef UART_FIFO_TIMEOUT_EN
    // Cycles since the last received byte while in WR.
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`endif

    assign tx_valid  = (state_q == RD_OUT);
    assign tx_data   = tx_valid ? ram_rdata : 8'h00;
    assign fifo_busy = (state_q != IDLE);
    assign fifo_done = (state_q == DONE);
    assign level     = wr_ptr_q - rd_ptr_q;
    assign err       = err_q;

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// tb/tb_uart_fifo_ctrl.sv - randomized self-checking bench for uart_fifo_ctrl against a queue model
module tb_uart_fifo_ctrl;

    localparam int DEPTH = 256;
    localparam logic [7:0] C_WR  = 8'h01;
    localparam logic [7:0] C_RD  = 8'h02;
    localparam logic [7:0] C_CLR = 8'h03;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  cmd;
    logic [15:0] rx_cnt;
    logic        rok;
    logic [7:0]  mosi;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        fifo_busy;
    logic        fifo_done;
    logic [8:0]  level;
    logic        err;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;

    logic [7:0] model_q[$];
    logic [7:0] pend[$];
    logic       model_err = 1'b0;

    logic       hold_chk = 1'b0;
    logic [7:0] hold_data = 8'h00;

    always #5 clk = ~clk;

    uart_fifo_ctrl #(
`ifdef UART_FIFO_TIMEOUT_EN
        .TIMEOUT_CYC(50),
`endif
        .DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd       (cmd),
        .rx_cnt    (rx_cnt),
        .rok       (rok),
        .mosi      (mosi),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .fifo_busy (fifo_busy),
        .fifo_done (fifo_done),
        .level     (level),
        .err       (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (fifo_done === 1'b1) done_cnt++;
    end

    // Offered transmit byte must stay put while the transmitter stalls.
    always @(negedge clk) begin
        if (hold_chk) check("tx_hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, hold_data});
        hold_chk  = (tx_valid === 1'b1) && (tx_ready === 1'b0) && (rst === 1'b0);
        hold_data = tx_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [7:0] c, input logic [15:0] n);
        cmd    = c;
        rx_cnt = n;
        tick();
        cmd    = 8'h00;
        rx_cnt = 16'($urandom);
        check("busy_rise", fifo_busy, 1);
    endtask

    task automatic finish_txn(input int d0);
        tick();
        check("idle_busy", fifo_busy, 0);
        check("done_pulses", done_cnt - d0, 1);
        check("level", level, model_q.size());
        check("err", err, model_err);
    endtask

    task automatic wr_txn(input int n, input int maxgap);
        int d0;
        logic [7:0] b;
        d0 = done_cnt;
        issue(C_WR, 16'(n));
        if (n == 0) begin
            check("wr0_early", fifo_done, 0);
            tick();
            check("wr0_done", fifo_done, 1);
        end else begin
            for (int i = 0; i < n; i++) begin
                repeat ($urandom_range(0, maxgap)) begin
                    mosi = 8'($urandom);
                    tick();
                end
                b = (pend.size() > 0) ? pend.pop_front() : 8'($urandom);
                rok  = 1'b1;
                mosi = b;
                tick();
                rok  = 1'b0;
                if (model_q.size() < DEPTH) model_q.push_back(b);
                else model_err = 1'b1;
                check("wr_level", level, model_q.size());
                check("wr_done", fifo_done, (i == n - 1) ? 1 : 0);
            end
        end
        finish_txn(d0);
    endtask

    task automatic rd_txn(input int n, input bit rnd_ready);
        int d0, sent, exp_sent, k;
        bit found;
        d0 = done_cnt;
        exp_sent = (n < model_q.size()) ? n : model_q.size();
        if (n > model_q.size()) model_err = 1'b1;
        sent  = 0;
        found = 0;
        issue(C_RD, 16'(n));
        for (k = 0; k < 4 * n + 20; k++) begin
            if (fifo_done) begin
                found = 1;
                break;
            end
            tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : (k % 2 == 0);
            if (tx_valid && tx_ready) begin
                if (model_q.size() > 0) check("rd_data", tx_data, model_q.pop_front());
                else check("rd_extra", 1, 0);
                sent++;
            end
            tick();
        end
        tx_ready = 1'b0;
        if (!found) check("rd_wait_done", 0, 1);
        check("rd_sent", sent, exp_sent);
        finish_txn(d0);
    endtask

    task automatic special_txn(input logic [7:0] c);
        int d0;
        d0 = done_cnt;
        issue(c, 16'($urandom));
        check("sp_early", fifo_done, 0);
        tick();
        check("sp_done", fifo_done, 1);
        check("sp_busy", fifo_busy, 1);
        if (c == C_CLR) begin
            model_q.delete();
            model_err = 1'b0;
        end else begin
            model_err = 1'b1;
        end
        finish_txn(d0);
    endtask

    initial begin
        int d0, op, lat;
        rst = 1'b1; cmd = 8'h00; rx_cnt = 16'd0; rok = 1'b0; mosi = 8'h00; tx_ready = 1'b0;
        repeat (3) tick();
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_busy", fifo_busy, 0);
        check("rst_done", fifo_done, 0);
        check("rst_level", level, 0);
        check("rst_err", err, 0);
        rst = 1'b0;
        tick();

        pend = '{8'hA1, 8'hB2, 8'hC3};
        wr_txn(3, 2);
        rd_txn(3, 1'b0);
        wr_txn(2, 1);
        rd_txn(5, 1'b1);
        special_txn(C_CLR);
        wr_txn(DEPTH + 2, 0);
        special_txn(C_CLR);
        wr_txn(4, 0);
        special_txn(8'h7F);
        rd_txn(0, 1'b1);
        wr_txn(0, 0);

        for (int it = 0; it < 40; it++) begin
            op = $urandom_range(0, 9);
            if (op <= 3) wr_txn($urandom_range(0, 24), 3);
            else if (op <= 6) rd_txn($urandom_range(0, model_q.size() + 3), 1'b1);
            else if (op == 7) special_txn(C_CLR);
            else special_txn(8'($urandom_range(4, 255)));
        end

        d0 = done_cnt;
        issue(C_WR, 16'd10);
        for (int i = 0; i < 3; i++) begin
            rok = 1'b1; mosi = 8'($urandom); tick(); rok = 1'b0;
        end
        rst = 1'b1;
        tick();
        check("rstmid_busy", fifo_busy, 0);
        check("rstmid_level", level, 0);
        check("rstmid_done", fifo_done, 0);
        rst = 1'b0;
        model_q.delete();
        model_err = 1'b0;
        tick();
        tick();
        check("rstmid_pulses", done_cnt - d0, 0);
        check("rstmid_err", err, 0);

`ifdef UART_FIFO_TIMEOUT_EN
        d0 = done_cnt;
        issue(C_WR, 16'd4);
        for (int i = 0; i < 2; i++) begin
            rok = 1'b1; mosi = 8'($urandom); model_q.push_back(mosi); tick(); rok = 1'b0;
        end
        lat = 1;
        while (!fifo_done && lat < 100) begin
            tick();
            lat++;
        end
        check("timeout_lat", lat, 50);
        model_err = 1'b1;
        finish_txn(d0);
`else
        lat = 0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
